// File: rtl/dino_pkg.sv
// Shared definitions for the dinosaur game stages: FSM states, LFSR
// constants and default playfield geometry (also used by the renderer).
package dino_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting left; feedback from bits 7,5,4,3
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Default geometry in pixels
    localparam int SCREEN_W_DEF = 640;
    localparam int DINO_X_DEF   = 64;
    localparam int DINO_W_DEF   = 20;
    localparam int OBST_W_DEF   = 16;
    localparam int OBST_H_DEF   = 24;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/obstacle_collision_if.sv
// Game-control bus between the jump stage / game logic and the obstacle stage.
interface obstacle_collision_if;
    logic        start;
    logic [6:0]  jump_h;
    logic        halt;
    logic [10:0] obst_x;
    logic [13:0] score;
    logic        score_tick;
    logic        game_over;

    // master: the side driving start/jump_h and consuming the status
    modport master (output start, jump_h,
                    input  halt, obst_x, score, score_tick, game_over);
    // slave: the obstacle/collision stage itself
    modport slave  (input  start, jump_h,
                    output halt, obst_x, score, score_tick, game_over);
endinterface

// File: rtl/obstacle_collision_tick_gen.sv
// Step divider: counts 0..STEP_CYCLES-1 while enabled and emits a one-cycle
// step pulse on terminal count. Clear has priority over enable.
module tick_gen #(
    parameter int STEP_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_step
);
    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    // Divider counter, frozen when not enabled
    always_ff @(posedge clk) begin
        if (reset || i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= (r_cnt == TERM) ? '0 : r_cnt + 1'b1;
    end

    assign o_step = i_en && (r_cnt == TERM);

endmodule

// File: rtl/obstacle_collision.sv
// Obstacle scroller and collision detector. Scrolls one obstacle right to
// left, checks overlap with the dinosaur each RUN cycle, keeps the score.
// Optional feature: OBSTACLE_RANDOM_GAP_EN adds an LFSR-driven random
// spawn gap (reload = SCREEN_W + LFSR[5:0]); otherwise reload is SCREEN_W.
module obstacle_collision
    import dino_pkg::*;
#(
    parameter int STEP_CYCLES = 250000,
    parameter int SCREEN_W    = SCREEN_W_DEF,
    parameter int DINO_X      = DINO_X_DEF,
    parameter int DINO_W      = DINO_W_DEF,
    parameter int OBST_W      = OBST_W_DEF,
    parameter int OBST_H      = OBST_H_DEF,
    parameter int SCORE_MAX   = 9999
) (
    input  logic               clk,
    input  logic               reset,
    obstacle_collision_if.slave bus
);
    state_t      r_state, w_state_nx;
    logic [10:0] r_x;
    logic [13:0] r_score;
    logic        r_tick, r_halt, r_over;
    logic        w_init, w_hit, w_step;
    logic [11:0] w_x12;
    logic [10:0] w_reload;
    logic [13:0] w_score_inc;

    // Overlap test on registered position, 12-bit so x+OBST_W cannot wrap
    assign w_x12 = {1'b0, r_x};
    assign w_hit = (r_state == ST_RUN)
                && (w_x12 < 12'(DINO_X + DINO_W))
                && ((w_x12 + 12'(OBST_W)) > 12'(DINO_X))
                && ({5'd0, bus.jump_h} < 12'(OBST_H));

    assign w_score_inc = (r_score >= 14'(SCORE_MAX)) ? r_score : r_score + 14'd1;

`ifdef OBSTACLE_RANDOM_GAP_EN
    logic [7:0] r_lfsr;

    // Free-running gap generator, advances every clock in every state
    always_ff @(posedge clk) begin
        if (reset) r_lfsr <= LFSR_SEED;
        else       r_lfsr <= lfsr_next(r_lfsr);
    end

    assign w_reload = 11'(SCREEN_W) + {5'd0, r_lfsr[5:0]};
`else
    assign w_reload = 11'(SCREEN_W);
`endif

    // Divider runs only in RUN; a colliding cycle's step is dropped
    tick_gen #(.STEP_CYCLES(STEP_CYCLES)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_init),
        .i_en   ((r_state == ST_RUN) && !w_hit),
        .o_step (w_step)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nx;
    end

    // FSM next state; w_init flags a (re)start from IDLE or OVER
    always_comb begin
        w_state_nx = r_state;
        w_init     = 1'b0;
        case (r_state)
            ST_IDLE, ST_OVER: if (bus.start) begin
                w_state_nx = ST_RUN;
                w_init     = 1'b1;
            end
            ST_RUN:  if (w_hit) w_state_nx = ST_OVER;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Obstacle position, score and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x     <= 11'(SCREEN_W);
            r_score <= '0;
            r_tick  <= 1'b0;
            r_halt  <= 1'b1;
            r_over  <= 1'b0;
        end else begin
            r_halt <= (w_state_nx != ST_RUN);
            r_over <= (w_state_nx == ST_OVER);
            r_tick <= 1'b0;
            if (w_init) begin
                r_x     <= 11'(SCREEN_W);
                r_score <= '0;
            end else if (w_step) begin
                if (r_x == '0) begin
                    r_x     <= w_reload;
                    r_score <= w_score_inc;
                    r_tick  <= 1'b1;
                end else begin
                    r_x <= r_x - 1'b1;
                end
            end
        end
    end

    assign bus.halt       = r_halt;
    assign bus.obst_x     = r_x;
    assign bus.score      = r_score;
    assign bus.score_tick = r_tick;
    assign bus.game_over  = r_over;

endmodule

// File: tb/tb_obstacle_collision.sv
// Directed bench for obstacle_collision with a small playfield. Expected
// outputs are queued as each cycle is driven and popped after the edge.
// SCORE_MAX is kept small so saturation is reached in a short run.
module tb_obstacle_collision;
    localparam int SC   = 4;
    localparam int SW   = 40;
    localparam int DX   = 8;
    localparam int DW   = 4;
    localparam int OW   = 4;
    localparam int OH   = 10;
    localparam int SMAX = 2;
    localparam int LAP  = (SW + 1) * SC;   // clocks per full pass, fixed gap

    typedef struct packed {
        logic        halt;
        logic [10:0] x;
        logic [13:0] sc;
        logic        tick;
        logic        go;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    obstacle_collision_if bus();

    obstacle_collision #(
        .STEP_CYCLES(SC), .SCREEN_W(SW), .DINO_X(DX), .DINO_W(DW),
        .OBST_W(OW), .OBST_H(OH), .SCORE_MAX(SMAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic exp_t mk(input int h, input int x, input int s, input int t, input int g);
        exp_t e;
        e.halt = 1'(h);
        e.x    = 11'(x);
        e.sc   = 14'(s);
        e.tick = 1'(t);
        e.go   = 1'(g);
        return e;
    endfunction

    // Advance one clock, then compare the oldest queued expectation
    task automatic step_chk(input string tag);
        exp_t e, o;
        @(posedge clk); #1;
        e = q.pop_front();
        o = '{bus.halt, bus.obst_x, bus.score, bus.score_tick, bus.game_over};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed halt=%0b x=%0d score=%0d tick=%0b over=%0b, expected halt=%0b x=%0d score=%0d tick=%0b over=%0b",
                   tag, o.halt, o.x, o.sc, o.tick, o.go, e.halt, e.x, e.sc, e.tick, e.go);
        end
    endtask

    task automatic cyc(input exp_t e, input string tag);
        q.push_back(e);
        step_chk(tag);
    endtask

`ifdef OBSTACLE_RANDOM_GAP_EN
    logic [7:0] tb_lfsr;
    logic [10:0] gapq[$];

    // Reference LFSR: x^8+x^6+x^5+x^4+1, seeded on reset
    always @(posedge clk) begin
        if (reset) tb_lfsr <= 8'hA5;
        else       tb_lfsr <= {tb_lfsr[6:0], tb_lfsr[7] ^ tb_lfsr[5] ^ tb_lfsr[4] ^ tb_lfsr[3]};
    end
`endif

    initial begin
        bus.start  = 1'b0;
        bus.jump_h = 7'd0;

        // Reset values while reset is held
        reset = 1'b1;
        cyc(mk(1, SW, 0, 0, 0), "reset0");
        cyc(mk(1, SW, 0, 0, 0), "reset1");
        reset = 1'b0;

        // IDLE with start low: everything static
        for (int n = 0; n < 50; n++) cyc(mk(1, SW, 0, 0, 0), "idle");

`ifdef OBSTACLE_RANDOM_GAP_EN
        // Random gap: every reload equals SW + gap from the reference LFSR
        begin
            int ticks = 0;
            logic [10:0] cand, got;
            bus.jump_h = 7'd20;
            bus.start  = 1'b1;
            cyc(mk(0, SW, 0, 0, 0), "rnd_start");
            bus.start = 1'b0;
            for (int n = 0; n < 1500; n++) begin
                gapq.push_back(11'(SW) + {5'd0, tb_lfsr[5:0]});
                @(posedge clk); #1;
                cand = gapq.pop_front();
                if (bus.score_tick) begin
                    ticks++;
                    got = bus.obst_x;
                    checks++;
                    assert (got === cand && got >= 11'(SW) && got <= 11'(SW + 63)) else begin
                        errors++;
                        $error("FAIL rnd_reload: observed x=%0d, expected x=%0d", got, cand);
                    end
                end
            end
            checks++;
            assert (ticks > 0) else begin
                errors++;
                $error("FAIL rnd_ticks: observed %0d reloads, expected at least 1", ticks);
            end
        end
`else
        // Run with dinosaur in the air: steps, wraps, score saturation,
        // and start held mid-run must be ignored
        bus.jump_h = 7'd20;
        bus.start  = 1'b1;
        cyc(mk(0, SW, 0, 0, 0), "run_start");
        bus.start = 1'b0;
        for (int n = 1; n <= 500; n++) begin
            int lap, w;
            bus.start = (n >= 50 && n < 60);
            lap = n / LAP;
            w   = n % LAP;
            cyc(mk(0, SW - w / SC, (lap > SMAX) ? SMAX : lap,
                   (lap > 0 && w == 0) ? 1 : 0, 0), "run");
        end
`endif

        // Reset together with start mid-RUN: reset wins
        bus.start = 1'b1;
        reset     = 1'b1;
        cyc(mk(1, SW, 0, 0, 0), "rst_start");
        reset     = 1'b0;
        bus.start = 1'b0;
        for (int n = 0; n < 5; n++) cyc(mk(1, SW, 0, 0, 0), "post_rst");

        // Grounded dinosaur: first overlap at x = DX+DW-1 = 11
        bus.jump_h = 7'd0;
        bus.start  = 1'b1;
        cyc(mk(0, SW, 0, 0, 0), "col_start");
        bus.start = 1'b0;
        for (int n = 1; n <= 130; n++) begin
            if (n <= 116) cyc(mk(0, SW - n / SC, 0, 0, 0), "col_run");
            else          cyc(mk(1, 11, 0, 0, 1), "col_over");
        end

        // Restart from OVER; collide on the step cycle at x=11 (step dropped)
        bus.jump_h = 7'd20;
        bus.start  = 1'b1;
        cyc(mk(0, SW, 0, 0, 0), "step_start");
        bus.start = 1'b0;
        for (int n = 1; n <= 125; n++) begin
            if (n == 120) bus.jump_h = 7'd0;
            if (n <= 119) cyc(mk(0, SW - n / SC, 0, 0, 0), "step_run");
            else          cyc(mk(1, 11, 0, 0, 1), "step_over");
        end

        // Restart after OVER re-initialises position and score
        bus.jump_h = 7'd20;
        bus.start  = 1'b1;
        cyc(mk(0, SW, 0, 0, 0), "restart");
        bus.start = 1'b0;
        for (int n = 1; n <= 8; n++) cyc(mk(0, SW - n / SC, 0, 0, 0), "restart_run");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
